pop_sequence_ctrl: RTL and testbench
====================================

# pop_sequence_ctrl

Sequences the four-phase pulsed-optical-pumping cycle (pump, dark, probe, wait) on top of the free-running slow clock divider. Durations of each phase are counted in ticks taken from a divider output. The block drives the pump and probe gate lines and reports run status to the front-panel and host logic. It runs a programmed number of cycles, or runs continuously, under a start/stop handshake.

## Interface
- CNT_W, 16: width of each phase-duration field and of the tick counter.
- NCYC_W, 8: width of the cycle-count field and of the cycle counter.
- clk  in  1  system clock (2.5 MHz board clock)
- rst  in  1  asynchronous, active-high reset
- tick_in  in  1  level from the divider (e.g. the 100 us debounce output), asynchronous to logic use; each rising edge is one tick
- start  in  1  single-cycle request; honoured only in IDLE
- stop  in  1  abort request; honoured in any non-IDLE state
- dur_pump, dur_dark, dur_probe, dur_wait  in  CNT_W each  phase lengths in ticks, sampled at start
- n_cycles  in  NCYC_W  cycles per run, sampled at start; 0 means continuous
- pump_gate  out  1  high throughout PUMP
- probe_gate  out  1  high throughout PROBE
- phase  out  2  0 = pump, 1 = dark, 2 = probe, 3 = wait; 0 in IDLE
- busy  out  1  high in any state other than IDLE
- first_cycle  out  1  high during the first cycle of a run
- done  out  1  one-clk pulse when a finite run completes

## Operation
- States: IDLE, PUMP, DARK, PROBE, WAIT. All outputs are registered and derived from state.
- IDLE with start=1 and stop=0:
  - latch all durations and n_cycles into shadow registers;
  - clear cycle_cnt; set first_cycle;
  - enter PUMP on the next edge, independent of tick.
- Phase entry loads tick_cnt with max(dur,1). A duration of 0 behaves as 1.
- Each detected tick decrements tick_cnt. A tick seen while tick_cnt==1 advances the state on that edge: PUMP→DARK→PROBE→WAIT.
- WAIT exit:
  - cycle_cnt increments and first_cycle clears;
  - if n_cycles≠0 and cycle_cnt+1==n_cycles, go to IDLE and pulse done;
  - otherwise go to PUMP.
- Continuous mode (n_cycles=0): cycle_cnt wraps modulo 2^NCYC_W and is ignored.
- stop while busy: go to IDLE on the next edge. Gates drop, and done is not pulsed.
- start while busy is ignored. Input changes while busy do not affect the run.
- start and stop together in IDLE: stop wins, and the block stays IDLE.
- Reset, including mid-run: state IDLE; tick_cnt and cycle_cnt 0; pump_gate, probe_gate, busy, first_cycle and done 0; phase 0; synchroniser flops 0.

## Timing
- Tick detection: two-flop synchroniser, then rising-edge detect. A tick_in rise produces a one-clk tick strobe 3 clk later.
- start to busy/pump_gate high: 1 clk.
- The last tick of a phase to the next phase outputs: 1 clk. A phase therefore lasts exactly dur ticks, measured between tick strobes, after a first-phase alignment of up to one tick period.
- stop to gates low and busy low: 1 clk.
- done is coincident with the first IDLE cycle and lasts 1 clk.
- tick_in must stay high and low for at least 2 clk each. Faster toggling is outside spec.

## Configuration
- POP_TRIGGER_OUT_EN defined: adds output trig_out (1 bit, reset 0). It pulses high for 1 clk on the first cycle of every PROBE phase, to trigger the acquisition card.
- Macro undefined: port and logic are absent, and all other behaviour is identical.

## Structure
- Package pop_seq_pkg holds:
  - the state enum (IDLE, PUMP, DARK, PROBE, WAIT);
  - phase code constants PH_PUMP=0, PH_DARK=1, PH_PROBE=2, PH_WAIT=3;
  - default CNT_W/NCYC_W localparams.
- Sub-module tick_sync: two-flop synchroniser plus rising-edge detector, with ports clk, rst, tick_in, tick_stb. It is reusable for front-panel button inputs.

## Test plan
- Durations 3/2/4/1, n_cycles=2, tick every 10 clk, start pulse. Check:
  - pump_gate high 3 ticks, probe_gate high 4 ticks, phase sequence 0,1,2,3,0,1,2,3;
  - first_cycle high only during the first cycle;
  - done pulses 1 clk at the end, then busy=0.
- dur_dark=0 → DARK lasts exactly 1 tick.
- n_cycles=0 runs ≥300 cycles with no done. stop mid-PROBE → probe_gate and busy low 1 clk later, no done.
- start and stop asserted together in IDLE → busy stays 0. start pulsed during a run → no effect on phase timing.
- rst asserted mid-PUMP → all outputs 0 immediately. After release, a new start runs normally.
- With POP_TRIGGER_OUT_EN: trig_out pulses once per PROBE entry, coincident with probe_gate rising.

Source files
------------

// File: rtl/pop_seq_pkg.sv
// Shared types and constants for the pulsed-optical-pumping sequencer.
package pop_seq_pkg;

   localparam int CNT_W_DEF  = 16;
   localparam int NCYC_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PUMP  = 3'd1,
      DARK  = 3'd2,
      PROBE = 3'd3,
      WAIT  = 3'd4
   } state_t;

   localparam logic [1:0] PH_PUMP  = 2'd0;
   localparam logic [1:0] PH_DARK  = 2'd1;
   localparam logic [1:0] PH_PROBE = 2'd2;
   localparam logic [1:0] PH_WAIT  = 2'd3;

   // Phase code reported on the status bus; IDLE reads as pump (0).
   function automatic logic [1:0] phase_of(input state_t s);
      case (s)
         DARK:    phase_of = PH_DARK;
         PROBE:   phase_of = PH_PROBE;
         WAIT:    phase_of = PH_WAIT;
         default: phase_of = PH_PUMP;
      endcase
   endfunction

endpackage

// File: rtl/tick_sync.sv
// Two-flop synchroniser plus rising-edge detector. A rise on tick_in gives a
// one-clk tick_stb three clocks later. Also usable for front-panel buttons.
module tick_sync (
   input  logic clk,
   input  logic rst,
   input  logic tick_in,
   output logic tick_stb
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic r_stb;

   // Synchronise the asynchronous level and register the rising-edge strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_stb   <= 1'b0;
      end else begin
         r_sync1 <= tick_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_stb   <= r_sync2 & ~r_prev;
      end
   end

   assign tick_stb = r_stb;

endmodule

// File: rtl/pop_sequence_ctrl.sv
// Four-phase pump/dark/probe/wait sequencer clocked by divider ticks.
// Optional acquisition trigger output enabled by POP_TRIGGER_OUT_EN.
module pop_sequence_ctrl
   import pop_seq_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int NCYC_W = NCYC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_in,
   input  logic              start,
   input  logic              stop,
   input  logic [CNT_W-1:0]  dur_pump,
   input  logic [CNT_W-1:0]  dur_dark,
   input  logic [CNT_W-1:0]  dur_probe,
   input  logic [CNT_W-1:0]  dur_wait,
   input  logic [NCYC_W-1:0] n_cycles,
   output logic              pump_gate,
   output logic              probe_gate,
   output logic [1:0]        phase,
   output logic              busy,
   output logic              first_cycle,
   output logic              done
`ifdef POP_TRIGGER_OUT_EN
   ,output logic             trig_out
`endif
);

   // A programmed zero-length phase still occupies one tick.
   function automatic logic [CNT_W-1:0] ld_dur(input logic [CNT_W-1:0] d);
      ld_dur = (d == '0) ? CNT_W'(1) : d;
   endfunction

   logic              w_tick;
   state_t            r_state;
   logic [CNT_W-1:0]  r_tick_cnt;
   logic [NCYC_W-1:0] r_cyc_cnt;
   logic [NCYC_W-1:0] r_n_cyc;
   logic [CNT_W-1:0]  r_dur_pump, r_dur_dark, r_dur_probe, r_dur_wait;
   logic              r_pump_gate, r_probe_gate, r_busy, r_first, r_done;
   logic [1:0]        r_phase;

   state_t            w_nxt_state;
   logic [CNT_W-1:0]  w_nxt_tick;
   logic [NCYC_W-1:0] w_nxt_cyc;
   logic [NCYC_W-1:0] w_cyc_inc;
   logic              w_nxt_first;
   logic              w_nxt_done;
   logic              w_latch;

   tick_sync u_tick_sync (
      .clk      (clk),
      .rst      (rst),
      .tick_in  (tick_in),
      .tick_stb (w_tick)
   );

   assign w_cyc_inc = r_cyc_cnt + 1'b1;

   // Next-state, counter and status decisions for the sequencer.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_tick  = r_tick_cnt;
      w_nxt_cyc   = r_cyc_cnt;
      w_nxt_first = r_first;
      w_nxt_done  = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         IDLE: begin
            // stop beats a simultaneous start; the run starts without a tick.
            if (start && !stop) begin
               w_nxt_state = PUMP;
               w_nxt_tick  = ld_dur(dur_pump);
               w_nxt_cyc   = '0;
               w_nxt_first = 1'b1;
               w_latch     = 1'b1;
            end
         end
         default: begin
            if (stop) begin
               w_nxt_state = IDLE;
               w_nxt_tick  = '0;
               w_nxt_first = 1'b0;
            end else if (w_tick) begin
               if (r_tick_cnt <= CNT_W'(1)) begin
                  case (r_state)
                     PUMP: begin
                        w_nxt_state = DARK;
                        w_nxt_tick  = ld_dur(r_dur_dark);
                     end
                     DARK: begin
                        w_nxt_state = PROBE;
                        w_nxt_tick  = ld_dur(r_dur_probe);
                     end
                     PROBE: begin
                        w_nxt_state = WAIT;
                        w_nxt_tick  = ld_dur(r_dur_wait);
                     end
                     default: begin
                        // End of a cycle; a finite run stops on its last one.
                        w_nxt_cyc   = w_cyc_inc;
                        w_nxt_first = 1'b0;
                        if (r_n_cyc != '0 && w_cyc_inc == r_n_cyc) begin
                           w_nxt_state = IDLE;
                           w_nxt_tick  = '0;
                           w_nxt_done  = 1'b1;
                        end else begin
                           w_nxt_state = PUMP;
                           w_nxt_tick  = ld_dur(r_dur_pump);
                        end
                     end
                  endcase
               end else begin
                  w_nxt_tick = r_tick_cnt - 1'b1;
               end
            end
         end
      endcase
   end

   // State, counters, run shadows and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_tick_cnt   <= '0;
         r_cyc_cnt    <= '0;
         r_n_cyc      <= '0;
         r_dur_pump   <= '0;
         r_dur_dark   <= '0;
         r_dur_probe  <= '0;
         r_dur_wait   <= '0;
         r_pump_gate  <= 1'b0;
         r_probe_gate <= 1'b0;
         r_busy       <= 1'b0;
         r_first      <= 1'b0;
         r_done       <= 1'b0;
         r_phase      <= PH_PUMP;
      end else begin
         r_state      <= w_nxt_state;
         r_tick_cnt   <= w_nxt_tick;
         r_cyc_cnt    <= w_nxt_cyc;
         r_pump_gate  <= (w_nxt_state == PUMP);
         r_probe_gate <= (w_nxt_state == PROBE);
         r_busy       <= (w_nxt_state != IDLE);
         r_first      <= w_nxt_first;
         r_done       <= w_nxt_done;
         r_phase      <= phase_of(w_nxt_state);
         if (w_latch) begin
            r_n_cyc     <= n_cycles;
            r_dur_pump  <= dur_pump;
            r_dur_dark  <= dur_dark;
            r_dur_probe <= dur_probe;
            r_dur_wait  <= dur_wait;
         end
      end
   end

   assign pump_gate   = r_pump_gate;
   assign probe_gate  = r_probe_gate;
   assign phase       = r_phase;
   assign busy        = r_busy;
   assign first_cycle = r_first;
   assign done        = r_done;

`ifdef POP_TRIGGER_OUT_EN
   logic r_trig;

   // One-clk acquisition trigger on every entry into PROBE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_trig <= 1'b0;
      else     r_trig <= (w_nxt_state == PROBE) && (r_state != PROBE);
   end

   assign trig_out = r_trig;
`endif

endmodule

// File: tb/tb_pop_sequence_ctrl.sv
// Directed bench for pop_sequence_ctrl; honours POP_TRIGGER_OUT_EN when defined.
module tb_pop_sequence_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick_in = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] dur_pump = '0, dur_dark = '0, dur_probe = '0, dur_wait = '0;
   logic [7:0]  n_cycles = '0;
   logic        pump_gate, probe_gate, busy, first_cycle, done;
   logic [1:0]  phase;
`ifdef POP_TRIGGER_OUT_EN
   logic        trig_out;
`endif

   pop_sequence_ctrl dut (
      .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
      .dur_pump(dur_pump), .dur_dark(dur_dark), .dur_probe(dur_probe), .dur_wait(dur_wait),
      .n_cycles(n_cycles), .pump_gate(pump_gate), .probe_gate(probe_gate), .phase(phase),
      .busy(busy), .first_cycle(first_cycle), .done(done)
`ifdef POP_TRIGGER_OUT_EN
      , .trig_out(trig_out)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;

   // Free-running divider model: 5 clk high, 5 clk low when enabled.
   bit tick_en = 1'b0;
   initial forever begin
      if (tick_en) begin
         tick_in = 1'b1; repeat (5) @(negedge clk);
         tick_in = 1'b0; repeat (5) @(negedge clk);
      end else @(negedge clk);
   end

   // Passive monitor: run lengths, phase entries, done and trigger activity.
   bit mon_en = 1'b0;
   int pump_runs[$], probe_runs[$], dark_runs[$], ph_seq[$], fc_seq[$];
   int pump_len, probe_len, dark_len, done_cnt, done_busy, pump_entries, trig_cnt, trig_bad;
   logic [1:0] prev_phase;
   logic prev_busy, prev_probe;

   always @(negedge clk) if (mon_en) begin
      if (pump_gate) pump_len++;
      else if (pump_len > 0) begin pump_runs.push_back(pump_len); pump_len = 0; end
      if (probe_gate) probe_len++;
      else if (probe_len > 0) begin probe_runs.push_back(probe_len); probe_len = 0; end
      if (busy && phase == 2'd1) dark_len++;
      else if (dark_len > 0) begin dark_runs.push_back(dark_len); dark_len = 0; end
      if (busy && (!prev_busy || phase != prev_phase)) begin
         ph_seq.push_back(int'(phase));
         fc_seq.push_back(int'(first_cycle));
         if (phase == 2'd0) pump_entries++;
      end
      if (done) begin done_cnt++; if (busy) done_busy++; end
`ifdef POP_TRIGGER_OUT_EN
      if (trig_out) trig_cnt++;
      if (trig_out !== (probe_gate && !prev_probe)) trig_bad++;
`endif
      prev_busy  = busy;
      prev_phase = phase;
      prev_probe = probe_gate;
   end

   task automatic mon_clear();
      pump_runs.delete(); probe_runs.delete(); dark_runs.delete();
      ph_seq.delete(); fc_seq.delete();
      pump_len = 0; probe_len = 0; dark_len = 0; done_cnt = 0; done_busy = 0;
      pump_entries = 0; trig_cnt = 0; trig_bad = 0;
      prev_phase = 2'd0; prev_busy = 1'b0; prev_probe = 1'b0;
   endtask

   task automatic set_run(input int p, input int d, input int pr, input int w, input int n);
      dur_pump = 16'(p); dur_dark = 16'(d); dur_probe = 16'(pr); dur_wait = 16'(w);
      n_cycles = 8'(n);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         @(negedge clk);
         if (done === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({pump_gate, probe_gate, busy, first_cycle, done, phase} !== 7'd0)
         $display("FAIL reset_outputs: got %b expected 0000000", {pump_gate, probe_gate, busy, first_cycle, done, phase});
      else n_pass++;
`ifdef POP_TRIGGER_OUT_EN
      n_checks++;
      if (trig_out !== 1'b0) $display("FAIL reset_trig: got %b expected 0", trig_out); else n_pass++;
`endif
      rst = 1'b0;
      mon_en = 1'b1;
      tick_en = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic_run();
      bit ok;
      int exp_ph[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int exp_fc[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
      int bad;
      set_run(3, 2, 4, 1, 2);
      mon_clear();
      pulse_start();
      n_checks++;
      if ({busy, pump_gate, phase, first_cycle} !== 5'b11001)
         $display("FAIL start_latency: got %b expected 11001", {busy, pump_gate, phase, first_cycle});
      else n_pass++;
      wait_done(1000, ok);
      n_checks++;
      if (!ok) $display("FAIL basic_done_seen: got 0 expected 1"); else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b expected 0", busy); else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if (done_cnt != 1 || done_busy != 0)
         $display("FAIL basic_done_pulse: got %0d clk (%0d busy) expected 1 (0)", done_cnt, done_busy);
      else n_pass++;
      n_checks++;
      if (pump_runs.size() != 2 || pump_runs[0] < 21 || pump_runs[0] > 30 || pump_runs[1] != 30)
         $display("FAIL basic_pump_len: got %p expected [21..30, 30]", pump_runs);
      else n_pass++;
      n_checks++;
      if (probe_runs.size() != 2 || probe_runs[0] != 40 || probe_runs[1] != 40)
         $display("FAIL basic_probe_len: got %p expected [40, 40]", probe_runs);
      else n_pass++;
      bad = (ph_seq.size() != 8);
      for (int i = 0; i < 8 && !bad; i++) if (ph_seq[i] != exp_ph[i]) bad = 1;
      n_checks++;
      if (bad) $display("FAIL basic_phase_seq: got %p expected 0,1,2,3,0,1,2,3", ph_seq); else n_pass++;
      bad = (fc_seq.size() != 8);
      for (int i = 0; i < 8 && !bad; i++) if (fc_seq[i] != exp_fc[i]) bad = 1;
      n_checks++;
      if (bad) $display("FAIL basic_first_cycle: got %p expected 1,1,1,1,0,0,0,0", fc_seq); else n_pass++;
      n_checks++;
      if (first_cycle !== 1'b0) $display("FAIL basic_first_idle: got %b expected 0", first_cycle); else n_pass++;
`ifdef POP_TRIGGER_OUT_EN
      n_checks++;
      if (trig_cnt != 2 || trig_bad != 0)
         $display("FAIL basic_trig: got %0d pulses %0d misaligned expected 2 and 0", trig_cnt, trig_bad);
      else n_pass++;
`endif
   endtask

   task automatic test_dark_zero();
      bit ok;
      set_run(2, 0, 2, 1, 1);
      mon_clear();
      pulse_start();
      wait_done(1000, ok);
      repeat (2) @(negedge clk);
      n_checks++;
      if (!ok || done_cnt != 1) $display("FAIL dark0_done: got %0d expected 1", done_cnt); else n_pass++;
      n_checks++;
      if (dark_runs.size() != 1 || dark_runs[0] != 10)
         $display("FAIL dark0_len: got %p expected [10]", dark_runs);
      else n_pass++;
   endtask

   task automatic test_continuous_stop();
      bit ok;
      set_run(1, 1, 1, 1, 0);
      mon_clear();
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 20000 && !ok; i++) begin
         @(negedge clk);
         if (pump_entries >= 301) ok = 1'b1;
      end
      n_checks++;
      if (!ok) $display("FAIL cont_cycles: got %0d pump entries expected >=301", pump_entries); else n_pass++;
      n_checks++;
      if (done_cnt != 0 || busy !== 1'b1)
         $display("FAIL cont_no_done: got done=%0d busy=%b expected 0 and 1", done_cnt, busy);
      else n_pass++;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (phase == 2'd2 && busy) ok = 1'b1;
      end
      n_checks++;
      if (!ok || probe_gate !== 1'b1) $display("FAIL cont_reach_probe: got probe_gate=%b expected 1", probe_gate); else n_pass++;
      stop = 1'b1;
      @(negedge clk) stop = 1'b0;
      n_checks++;
      if ({probe_gate, busy, pump_gate, phase} !== 5'd0)
         $display("FAIL stop_outputs: got %b expected 00000", {probe_gate, busy, pump_gate, phase});
      else n_pass++;
      repeat (30) @(negedge clk);
      n_checks++;
      if (done_cnt != 0 || busy !== 1'b0)
         $display("FAIL stop_no_done: got done=%0d busy=%b expected 0 and 0", done_cnt, busy);
      else n_pass++;
   endtask

   task automatic test_start_stop_idle();
      set_run(1, 1, 1, 1, 1);
      @(negedge clk) begin start = 1'b1; stop = 1'b1; end
      @(negedge clk) begin start = 1'b0; stop = 1'b0; end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL startstop_busy: got %b expected 0", busy); else n_pass++;
      repeat (20) @(negedge clk);
      n_checks++;
      if ({busy, pump_gate} !== 2'b00) $display("FAIL startstop_later: got %b expected 00", {busy, pump_gate}); else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit ok;
      set_run(3, 2, 4, 1, 1);
      mon_clear();
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (phase == 2'd1) ok = 1'b1;
      end
      set_run(9, 9, 7, 9, 5);
      pulse_start();
      wait_done(1000, ok);
      repeat (2) @(negedge clk);
      n_checks++;
      if (!ok || done_cnt != 1) $display("FAIL b2b_done: got %0d expected 1", done_cnt); else n_pass++;
      n_checks++;
      if (probe_runs.size() != 1 || probe_runs[0] != 40 || ph_seq.size() != 4)
         $display("FAIL b2b_timing: got probe %p, %0d phases expected [40], 4", probe_runs, ph_seq.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid_pump();
      bit ok;
      int bad;
      set_run(5, 1, 1, 1, 1);
      pulse_start();
      repeat (3) @(negedge clk);
      n_checks++;
      if (pump_gate !== 1'b1) $display("FAIL rstmid_pump: got %b expected 1", pump_gate); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({pump_gate, probe_gate, busy, first_cycle, done, phase} !== 7'd0)
         $display("FAIL rstmid_outputs: got %b expected 0000000", {pump_gate, probe_gate, busy, first_cycle, done, phase});
      else n_pass++;
      @(negedge clk) rst = 1'b0;
      set_run(1, 1, 1, 1, 1);
      mon_clear();
      pulse_start();
      n_checks++;
      if ({busy, pump_gate, first_cycle} !== 3'b111)
         $display("FAIL rstmid_restart: got %b expected 111", {busy, pump_gate, first_cycle});
      else n_pass++;
      wait_done(500, ok);
      repeat (2) @(negedge clk);
      bad = (ph_seq.size() != 4);
      for (int i = 0; i < 4 && !bad; i++) if (ph_seq[i] != i) bad = 1;
      n_checks++;
      if (!ok || done_cnt != 1 || bad)
         $display("FAIL rstmid_rerun: got done=%0d phases %p expected 1 and 0,1,2,3", done_cnt, ph_seq);
      else n_pass++;
   endtask

   initial begin
      mon_clear();
      test_reset();
      test_basic_run();
      test_dark_zero();
      test_continuous_stop();
      test_start_stop_idle();
      test_back_to_back();
      test_reset_mid_pump();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
